data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-side memory responder: the slave end of the CPU's data port (data_address, data_in, mem_read, mem_write, data_out).
- Adds a configurable wait-state latency, a one-cycle mem_ready completion pulse and an error flag, so the CPU can be exercised against multi-cycle memory.
- Drop-in replacement for the data half of the memory model in the CPU bench; the instruction path is out of scope.

Parameters:
ADDR_BITS, 8, log2 of word count (256 x 32-bit words)
WAIT_CYCLES, 2, edges from request accept to response; legal range 1..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
data_address  input  32  byte address from CPU
data_in  input  32  write data from CPU
mem_read  input  1  read strobe, level, held until mem_ready seen
mem_write  input  1  write strobe, level, held until mem_ready seen
data_out  output  32  read data, valid when mem_ready=1 and mem_err=0
mem_ready  output  1  one-cycle completion pulse
mem_err  output  1  error qualifier, valid only with mem_ready
busy  output  1  high in BUSY and RESP states

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, data_out=0, mem_ready=0, mem_err=0, busy=0. Memory array is not cleared; contents survive reset.
- States:
  - IDLE -> BUSY on the edge where mem_read or mem_write is sampled high. Latch address, write data, op and error class; counter = WAIT_CYCLES-1.
  - BUSY: decrement the counter each edge; when counter==0 at an edge, go to RESP.
  - RESP: lasts exactly one cycle with mem_ready=1; the next edge returns to IDLE.
- Latency: request sampled at edge N means mem_ready is high during the cycle after edge N+WAIT_CYCLES.
- Strobes are sampled only in IDLE. Strobe changes during BUSY or RESP are ignored. The CPU drops its strobe in the mem_ready cycle; a strobe still high at the RESP->IDLE edge is not sampled, and the first new accept is at the following edge.
- Word index = address[ADDR_BITS+1:2].
- Error class, latched at accept:
  - misaligned: address[1:0] != 0
  - out of range: address[31:ADDR_BITS+2] != 0
  - conflict: mem_read and mem_write both high
- Error response: mem_ready=1 and mem_err=1. No array write occurs, and data_out keeps its previous value.
- Good write: the array word is updated at the BUSY->RESP edge; mem_err=0.
- Good read: the array word is loaded into data_out at the BUSY->RESP edge. data_out then holds until the next good read completes (not cleared when mem_ready falls).
- A read of a never-written word returns X in simulation; benches must write before reading.
- mem_err=0 whenever mem_ready=0.
- busy=1 from the accept edge until the RESP->IDLE edge.
- Reset asserted mid-transaction aborts it immediately. A pending write that has not reached the BUSY->RESP edge is not committed, and no mem_ready is produced.
- Counter width is 4 bits. WAIT_CYCLES=1 goes IDLE->BUSY->RESP with no extra wait cycles (counter loaded 0).

Test Plan:
- Write/read: mem_write at address 0x10, data 0xDEADBEEF, WAIT_CYCLES=2 -> mem_ready pulses one cycle, 2 edges after accept, mem_err=0. Then mem_read at 0x10 -> data_out=0xDEADBEEF with mem_ready, held after the pulse.
- Misaligned: mem_read at 0x13 -> mem_ready=1, mem_err=1, data_out unchanged. Misaligned write at 0x22 with 0x12345678 -> a later read of 0x20 returns the prior value.
- Out of range: mem_write at 0x400 (ADDR_BITS=8) -> mem_err=1. A read at 0x000 is unaffected.
- Conflict: mem_read=mem_write=1 at 0x04 -> mem_err=1, no array write. busy is high for 3 cycles in total (accept through RESP).
- Reset mid-write: write 0xAAAA5555 to 0x08 (previously 0x11111111), rst=0 one cycle after accept -> no mem_ready, outputs 0. Read 0x08 after release -> 0x11111111.
- Back-to-back: two reads at 0x10 then 0x14 with the strobe dropped on mem_ready. The second accept falls 2 edges after the first pulse. Repeat with WAIT_CYCLES=1 and check the response arrives 1 edge after accept.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder                                                       |
// | Data-port memory slave with wait states, ready pulse and error flag.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_address,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int         c_depth     = 1 << ADDR_BITS;
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_index;
  logic [31:0]            r_wdata;
  logic                   r_write;
  logic                   r_err;
  logic [31:0]            r_data_out;
  logic [31:0]            r_mem [0:c_depth-1];

  logic w_accept;
  logic w_commit;
  logic w_misaligned;
  logic w_out_of_range;
  logic w_conflict;

  assign w_accept       = (r_state == ST_IDLE) && (mem_read || mem_write);
  assign w_commit       = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_misaligned   = |data_address[1:0];
  assign w_out_of_range = |data_address[31:ADDR_BITS+2];
  assign w_conflict     = mem_read && mem_write;

  always_comb begin
    w_state_next = r_state;
    mem_ready    = 1'b0;
    mem_err      = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
      ST_BUSY: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        busy         = 1'b1;
        mem_ready    = 1'b1;
        mem_err      = r_err;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_index    <= '0;
      r_wdata    <= 32'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_index <= data_address[ADDR_BITS+1:2];
        r_wdata <= data_in;
        r_write <= mem_write;
        r_err   <= w_misaligned || w_out_of_range || w_conflict;
        r_cnt   <= c_wait_load;
      end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // data_out only moves on a good read; errors leave the last value visible
      if (w_commit && !r_write && !r_err) r_data_out <= r_mem[r_index];
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (w_commit && r_write && !r_err) r_mem[r_index] <= r_wdata;
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder                                                    |
// | Directed vector bench for data_mem_responder (WAIT_CYCLES 2 and 1).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] dout0, dout1;
  logic        ready0, err0, busy0, ready1, err1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .data_address(addr0), .data_in(wdata0),
    .mem_read(rd0), .mem_write(wr0), .data_out(dout0),
    .mem_ready(ready0), .mem_err(err0), .busy(busy0)
  );

  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_address(addr1), .data_in(wdata1),
    .mem_read(rd1), .mem_write(wr1), .data_out(dout1),
    .mem_ready(ready1), .mem_err(err1), .busy(busy1)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ready1 : ready0;
  endfunction
  function automatic logic erf(input bit s);
    return s ? err1 : err0;
  endfunction
  function automatic logic bsy(input bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic logic [31:0] dat(input bit s);
    return s ? dout1 : dout0;
  endfunction

  task automatic drive(input bit s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  // One full transaction: accept, wait for the pulse, drop strobe, check the idle cycle
  task automatic txn(input bit s, input vec_t v, input int exp_lat, input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    drive(s, v.rd, v.wr, v.addr, v.wdata);
    @(posedge clk); #1;
    lat  = 0;
    bcnt = 0;
    while (!rdy(s) && lat < 20) begin
      if (bsy(s)) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (bsy(s)) bcnt++;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " mem_err"}, {31'd0, erf(s)}, {31'd0, v.err});
    chk({tag, " data_out"}, dat(s), v.dout);
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat + 1));
    @(negedge clk);
    drive(s, 1'b0, 1'b0, v.addr, v.wdata);
    @(posedge clk); #1;
    chk({tag, " ready after pulse"}, {31'd0, rdy(s)}, 32'd0);
    chk({tag, " err after pulse"}, {31'd0, erf(s)}, 32'd0);
    chk({tag, " busy after pulse"}, {31'd0, bsy(s)}, 32'd0);
    chk({tag, " data_out held"}, dat(s), v.dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, 1'b1, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0BAD_C0DE};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h4444_4444, 1'b0, 32'h0BAD_C0DE};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'h9999_9999, 1'b1, 32'h0BAD_C0DE};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h4444_4444};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 1'b0, 32'h4444_4444};
    vecs[13] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h4444_4444};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0014, 32'h1414_1414, 1'b0, 32'h4444_4444};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'h1414_1414};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("reset ready", {31'd0, ready0}, 32'd0);
    chk("reset err", {31'd0, err0}, 32'd0);
    chk("reset busy", {31'd0, busy0}, 32'd0);
    chk("reset data_out", dout0, 32'd0);
    chk("reset data_out w1", dout1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) txn(1'b0, vecs[i], 2, $sformatf("v%0d", i));

    // Abort a write to 0x08 one cycle after accept; old contents must survive
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_5555);
    @(posedge clk); #1;
    chk("abort busy at accept", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy0}, 32'd0);
    chk("abort ready", {31'd0, ready0}, 32'd0);
    chk("abort data_out", dout0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort no ready %0d", k), {31'd0, ready0}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post abort idle ready", {31'd0, ready0}, 32'd0);
    chk("post abort idle busy", {31'd0, busy0}, 32'd0);
    v = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h1111_1111};
    txn(1'b0, v, 2, "abort readback");

    // Single wait-state instance
    v = '{1'b0, 1'b1, 32'h0000_0030, 32'h3030_3030, 1'b0, 32'h0000_0000};
    txn(1'b1, v, 1, "w1 write");
    v = '{1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'h3030_3030};
    txn(1'b1, v, 1, "w1 read");
    v = '{1'b1, 1'b0, 32'h0000_0031, 32'h0, 1'b1, 32'h3030_3030};
    txn(1'b1, v, 1, "w1 misaligned");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
